display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
- Time-multiplexes four BCD digits (HH:MM) of the alarm clock onto one shared seven-segment decoder and a common-anode 4-digit display.
- Each scan slot drives one active-low anode and presents that digit's 4-bit code to the decoder.
- Handles tear-free frame updates, blinking of digits being edited, leading-zero suppression on the hours-tens digit, and global display enable.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range >= 1.
- BLINK_FRAMES, 64, full 4-digit frames per blink half-period; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- digits_in  in  16  BCD digits: [3:0] min ones, [7:4] min tens, [11:8] hr ones, [15:12] hr tens.
- display_en  in  1  1 = display on; 0 = all anodes off.
- blink_en  in  1  enables blinking of masked digits.
- blink_mask  in  4  bit i = digit i blinks when blink_en = 1.
- lz_blank  in  1  blank hr-tens digit when its value is 0.
- anode_n  out  4  one-hot active-low digit select, registered.
- bcd_out  out  4  code to the seven-segment decoder, registered; 4'hA = blank.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, idx = 0, shadow = 16'h0000, blink_cnt = 0, blink_phase = 0.
  - anode_n = 4'b1111, bcd_out = 4'hA, frame_start = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1), combinational. SCAN_DIV = 1 gives tick every cycle.
- Slot index idx (2 bits):
  - On each tick edge, idx advances 0→1→2→3→0.
  - Idx does not advance otherwise.
- Frame snapshot:
  - On a tick edge with idx == 3: shadow <= digits_in and frame_start <= 1.
  - frame_start is 0 on every other edge.
  - digits_in changes mid-frame never reach the outputs until the next snapshot.
  - Before the first snapshot after reset, shadow = 0 is displayed.
- Blink timing:
  - On each snapshot edge, blink_cnt increments.
  - When blink_cnt == BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles.
- Output register (updated every cycle from current idx/shadow; 1-cycle latency from an idx change):
  - display_en = 0: anode_n <= 4'b1111, bcd_out <= 4'hA.
  - Otherwise anode_n <= ~(4'b0001 << idx); d = shadow[4*idx+3 : 4*idx].
  - bcd_out <= 4'hA if blink_en & blink_mask[idx] & blink_phase.
  - Else bcd_out <= 4'hA if lz_blank & (idx == 3) & (d == 0).
  - Else bcd_out <= d.
- Data handling:
  - Non-BCD values (4'hA..4'hF) in digits_in pass through unmodified; the decoder shows blank/error.
- Free running:
  - Prescaler, idx, snapshot and blink logic run regardless of display_en, blink_en and lz_blank.
  - Toggling these inputs affects outputs on the next edge only, with no phase reset.
- Exactly one anode_n bit is low whenever display_en = 1, including the cycle after an idx change.
- Reset asserted mid-slot forces all state and outputs to reset values immediately.

Test Plan (SCAN_DIV = 4, BLINK_FRAMES = 2):
- Reset released, display_en = 1, digits_in = 16'h1234 → anode_n = 1110 / bcd_out = 0 for 4 cycles (shadow still 0). At the first tick with idx = 3, frame_start pulses once; the next slot shows anode_n = 1110, bcd_out = 4.
- Steady scan with 16'h1234 → slots cycle 1110/4, 1101/3, 1011/2, 0111/1, each exactly 4 cycles; frame_start every 16 cycles.
- Change digits_in to 16'h5678 while idx = 1 → remainder of frame still shows 3, 2, 1; next frame shows 8, 7, 6, 5.
- digits_in = 16'h0905, lz_blank = 1 → hr-tens slot bcd_out = A, others 5, 0, 9. With lz_blank = 0, hr-tens shows 0.
- blink_en = 1, blink_mask = 4'b0011 → min digits show A for 2 frames, then real values for 2 frames, repeating; hr digits never blank.
- display_en = 0 mid-slot → next edge anode_n = 1111, bcd_out = A. Re-enable → scan resumes at the current idx with no phase reset. Assert reset_n = 0 mid-frame → outputs go to 1111/A asynchronously.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes four BCD digits onto a shared decoder and common-anode display
module display_scan_controller #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] digits_in,
    input  logic        display_en,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    input  logic        lz_blank,
    output logic [3:0]  anode_n,
    output logic [3:0]  bcd_out,
    output logic        frame_start
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          tick;
    logic          snap;
    logic [3:0]    d;
    logic [3:0]    anode_nx;
    logic [3:0]    bcd_nx;

    assign tick = prescaler == PW'(SCAN_DIV - 1);
    assign snap = tick && idx == 2'd3;

    // slot timing: prescaler wraps every SCAN_DIV cycles and steps the slot index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) idx <= idx + 2'd1;
        end
    end

    // frame snapshot at the end of the last slot keeps each frame tear-free; also paces blinking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow      <= 16'h0000;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap;
            if (snap) begin
                shadow <= digits_in;
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    // next anode/code for the current slot; blink and leading-zero suppression both show blank
    always_comb begin
        d        = shadow[{idx, 2'b00} +: 4];
        anode_nx = 4'b1111;
        bcd_nx   = 4'hA;
        if (display_en) begin
            anode_nx = ~(4'b0001 << idx);
            bcd_nx   = ((blink_en && blink_mask[idx] && blink_phase) ||
                        (lz_blank && idx == 2'd3 && d == 4'h0)) ? 4'hA : d;
        end
    end

    // registered outputs so anode and code change together, glitch-free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anode_n <= 4'b1111;
            bcd_out <= 4'hA;
        end else begin
            anode_n <= anode_nx;
            bcd_out <= bcd_nx;
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard-checked scan, snapshot, blink, blanking and reset behaviour
module tb_display_scan_controller;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits_in = 16'h1234;
    logic        display_en = 1'b1;
    logic        blink_en = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  anode_n;
    logic [3:0]  bcd_out;
    logic        frame_start;

    int total = 0;
    int bad = 0;

    int          k;
    logic [15:0] msh;
    int          nsnap;
    logic [8:0]  sb[$];

    display_scan_controller #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .display_en(display_en),
        .blink_en(blink_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .anode_n(anode_n), .bcd_out(bcd_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        msh = 16'h0000;
        nsnap = 0;
    endtask

    task automatic step();
        int          i;
        logic [3:0]  d, ea, eb;
        logic        ef;
        logic [15:0] din;
        logic [8:0]  e;
        i   = (k / SD) % 4;
        d   = msh[i*4 +: 4];
        din = digits_in;
        ef  = (k % (4 * SD)) == (4 * SD - 1);
        ea  = display_en ? ~(4'b0001 << i) : 4'b1111;
        if (!display_en) eb = 4'hA;
        else if (blink_en && blink_mask[i] && ((nsnap / BF) % 2 == 1)) eb = 4'hA;
        else if (lz_blank && i == 3 && d == 4'h0) eb = 4'hA;
        else eb = d;
        sb.push_back({ea, eb, ef});
        @(posedge clk);
        if (ef) begin
            msh = din;
            nsnap++;
        end
        k++;
        #1;
        e = sb.pop_front();
        chk("anode_n", anode_n, e[8:5]);
        chk("bcd_out", bcd_out, e[4:1]);
        chk("frame_start", {3'b000, frame_start}, {3'b000, e[0]});
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_anode", anode_n, 4'b1111);
        chk("rst_bcd", bcd_out, 4'hA);
        chk("rst_fs", {3'b000, frame_start}, 4'h0);
        reset_n = 1'b1;
        model_reset();
        run(16);
        chk("first_snap_fs", {3'b000, frame_start}, 4'h1);
        run(1);
        chk("after_snap_anode", anode_n, 4'b1110);
        chk("after_snap_bcd", bcd_out, 4'h4);
        chk("after_snap_fs", {3'b000, frame_start}, 4'h0);
        run(31);
        for (int j = 0; j < 16 && ((k / SD) % 4) != 1; j++) step();
        digits_in = 16'h5678;
        run(40);
        digits_in = 16'h0905;
        lz_blank = 1'b1;
        run(36);
        lz_blank = 1'b0;
        run(20);
        blink_en = 1'b1;
        blink_mask = 4'b0011;
        run(80);
        run(2);
        display_en = 1'b0;
        run(5);
        display_en = 1'b1;
        run(10);
        digits_in = 16'h3AF1;
        run(22);
        reset_n = 1'b0;
        #2;
        chk("async_rst_anode", anode_n, 4'b1111);
        chk("async_rst_bcd", bcd_out, 4'hA);
        chk("async_rst_fs", {3'b000, frame_start}, 4'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        run(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
